// File: rtl/cpu_trace_monitor.sv
// Commit-trace monitor: captures CPU retire events into a FIFO and keeps cycle/instruction/drop counters.
// Defining CPU_TRACE_PC_EN adds the capture-time pc and inst to every entry (rd_pc, rd_inst outputs).
module cpu_trace_monitor #(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 16,
    parameter int CYCLE_W    = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [DATA_W-1:0]       pc,
    input  logic [DATA_W-1:0]       inst,
    input  logic                    reg_we,
    input  logic [REG_W-1:0]        reg_addr,
    input  logic [DATA_W-1:0]       reg_data,
    input  logic                    mem_re,
    input  logic                    mem_we,
    input  logic [DATA_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    hlt,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [3:0]              rd_flags,
    output logic [REG_W+DATA_W-1:0] rd_reg,
    output logic [2*DATA_W-1:0]     rd_mem,
    output logic [CYCLE_W-1:0]      rd_cycle,
    output logic [CYCLE_W-1:0]      cycle_cnt,
    output logic [CYCLE_W-1:0]      inst_cnt,
    output logic [CYCLE_W-1:0]      drop_cnt,
    output logic                    overflow,
    output logic [1:0]              state
`ifdef CPU_TRACE_PC_EN
    ,
    output logic [DATA_W-1:0]       rd_pc,
    output logic [DATA_W-1:0]       rd_inst
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HALTED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_e;

    typedef struct packed {
`ifdef CPU_TRACE_PC_EN
        logic [DATA_W-1:0]       pc;
        logic [DATA_W-1:0]       inst;
`endif
        logic [3:0]              flags;
        logic [REG_W+DATA_W-1:0] reg_f;
        logic [2*DATA_W-1:0]     mem;
        logic [CYCLE_W-1:0]      cycle;
    } entry_t;

    state_e             state_q, state_d;
    logic [CYCLE_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CYCLE_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [CYCLE_W-1:0] drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    entry_t             mem_q [DEPTH];
    entry_t             new_entry;
    entry_t             head;

    logic active, event_hit, fifo_empty, fifo_full, pop, push_ok;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                        (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
    assign active     = (state_q == S_RUN) && en;
    assign event_hit  = active && (reg_we | mem_re | mem_we | hlt);
    assign pop        = !fifo_empty && rd_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push_ok    = event_hit && (!fifo_full || pop);

    always_comb begin
        new_entry       = '0;
        new_entry.flags = {hlt, mem_we, mem_re, reg_we};
        new_entry.reg_f = {reg_addr, reg_data};
        new_entry.mem   = {mem_addr, mem_we ? mem_wdata : mem_rdata};
        new_entry.cycle = cycle_cnt_q;
`ifdef CPU_TRACE_PC_EN
        new_entry.pc    = pc;
        new_entry.inst  = inst;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        inst_cnt_d  = inst_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        overflow_d  = overflow_q;
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_ok);

        if (event_hit && !push_ok) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CYCLE_W'(1);
        end

        case (state_q)
            S_IDLE: if (en) state_d = S_RUN;
            S_RUN: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + CYCLE_W'(1);
                    if (hlt | reg_we | mem_we) inst_cnt_d = inst_cnt_q + CYCLE_W'(1);
                    if (hlt) state_d = S_HALTED;
                    else if (MAX_CYCLES != 0 && cycle_cnt_q == LAST_CYCLE) state_d = S_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // NOTE: the entry array is not reset; outputs are masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[IDX_W-1:0]] <= new_entry;
    end

    assign head      = fifo_empty ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
    assign rd_valid  = !fifo_empty;
    assign rd_flags  = head.flags;
    assign rd_reg    = head.reg_f;
    assign rd_mem    = head.mem;
    assign rd_cycle  = head.cycle;
    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;
    assign state     = state_q;

`ifdef CPU_TRACE_PC_EN
    assign rd_pc     = head.pc;
    assign rd_inst   = head.inst;
`else
    logic unused_pc_inst;
    assign unused_pc_inst = ^{pc, inst};
`endif

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor: directed scenarios plus randomized runs against a queue-based model.
module tb_cpu_trace_monitor;

    localparam int DATA_W  = 16;
    localparam int REG_W   = 4;
    localparam int DEPTH   = 16;
    localparam int CYCLE_W = 32;
    localparam int TB_MAX  = 40;

    localparam int ST_IDLE = 0, ST_RUN = 1, ST_HALTED = 2, ST_TIMEOUT = 3;

    logic                    clk = 1'b0;
    logic                    rst_n, en, reg_we, mem_re, mem_we, hlt, rd_ready;
    logic [DATA_W-1:0]       pc, inst, reg_data, mem_addr, mem_wdata, mem_rdata;
    logic [REG_W-1:0]        reg_addr;
    logic                    rd_valid, overflow;
    logic [3:0]              rd_flags;
    logic [REG_W+DATA_W-1:0] rd_reg;
    logic [2*DATA_W-1:0]     rd_mem;
    logic [CYCLE_W-1:0]      rd_cycle, cycle_cnt, inst_cnt, drop_cnt;
    logic [1:0]              state;

    always #5 clk = ~clk;

    cpu_trace_monitor #(
        .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .CYCLE_W(CYCLE_W), .MAX_CYCLES(TB_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pc(pc), .inst(inst),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_flags(rd_flags),
        .rd_reg(rd_reg), .rd_mem(rd_mem), .rd_cycle(rd_cycle),
        .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .drop_cnt(drop_cnt),
        .overflow(overflow), .state(state)
    );

    typedef struct packed {
        logic [3:0]  flags;
        logic [19:0] regv;
        logic [31:0] mem;
        logic [31:0] cyc;
    } entry_t;

    entry_t      mq[$];
    entry_t      exp_head;
    int          m_state = ST_IDLE;
    logic [31:0] m_cycle = '0, m_inst = '0, m_drop = '0;
    int          checks = 0, failures = 0;
    bit          cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per rising edge, using the inputs that edge sampled.
    task automatic model_step();
        bit     full, pop, evt;
        entry_t e;
        if (!rst_n) begin
            mq.delete();
            m_state = ST_IDLE;
            m_cycle = '0;
            m_inst  = '0;
            m_drop  = '0;
            return;
        end
        full = (mq.size() == DEPTH);
        pop  = (mq.size() != 0) && rd_ready;
        evt  = (m_state == ST_RUN) && en && (reg_we || mem_re || mem_we || hlt);
        if (pop) mq.delete(0);
        if (evt) begin
            if (!full || pop) begin
                e.flags = {hlt, mem_we, mem_re, reg_we};
                e.regv  = {reg_addr, reg_data};
                e.mem   = {mem_addr, (mem_we ? mem_wdata : mem_rdata)};
                e.cyc   = m_cycle;
                mq.push_back(e);
            end else if (m_drop != 32'hFFFF_FFFF) begin
                m_drop = m_drop + 1;
            end
        end
        if (m_state == ST_IDLE) begin
            if (en) m_state = ST_RUN;
        end else if (m_state == ST_RUN) begin
            if (!en) begin
                m_state = ST_IDLE;
            end else begin
                if (hlt) m_state = ST_HALTED;
                else if (m_cycle == TB_MAX - 1) m_state = ST_TIMEOUT;
                if (hlt || reg_we || mem_we) m_inst = m_inst + 1;
                m_cycle = m_cycle + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_head = (mq.size() != 0) ? mq[0] : '0;
            check("state",     state,     m_state);
            check("cycle_cnt", cycle_cnt, m_cycle);
            check("inst_cnt",  inst_cnt,  m_inst);
            check("drop_cnt",  drop_cnt,  m_drop);
            check("overflow",  overflow,  m_drop != 0);
            check("rd_valid",  rd_valid,  mq.size() != 0);
            check("rd_flags",  rd_flags,  exp_head.flags);
            check("rd_reg",    rd_reg,    exp_head.regv);
            check("rd_mem",    rd_mem,    exp_head.mem);
            check("rd_cycle",  rd_cycle,  exp_head.cyc);
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        reg_we = 0; mem_re = 0; mem_we = 0; hlt = 0;
        reg_addr = '0; reg_data = '0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
    endtask

    // One reset edge, then one IDLE cycle with en=1 so the monitor enters RUN.
    task automatic restart();
        idle();
        rst_n = 0; en = 1; rd_ready = 0;
        cycle();
        rst_n = 1;
        cycle();
    endtask

    initial begin
        rst_n = 0; en = 1; rd_ready = 0; pc = '0; inst = '0;
        idle();

        // Reset held two edges, then en=1 moves IDLE to RUN.
        cycle();
        cmp_en = 1'b1;
        cycle();
        rst_n = 1;
        check("rst_state",    state,     0);
        check("rst_cycle",    cycle_cnt, 0);
        check("rst_inst",     inst_cnt,  0);
        check("rst_drop",     drop_cnt,  0);
        check("rst_rd_valid", rd_valid,  0);
        check("rst_overflow", overflow,  0);
        cycle();
        check("run_state", state, 1);

        // RUN cycle 0: single register write.
        reg_we = 1; reg_addr = 4'd3; reg_data = 16'h00A5;
        cycle();
        idle();
        check("w0_valid", rd_valid, 1);
        check("w0_flags", rd_flags, 4'b0001);
        check("w0_reg",   rd_reg,   20'h300A5);
        check("w0_cycle", rd_cycle, 0);
        check("w0_inst",  inst_cnt, 1);

        // RUN cycle 1: store plus register write in one entry, popping the first entry.
        reg_we = 1; reg_addr = 4'd5; reg_data = 16'h0077;
        mem_we = 1; mem_addr = 16'h0040; mem_wdata = 16'h1234; mem_rdata = 16'hBEEF;
        rd_ready = 1;
        cycle();
        idle();
        check("st_flags", rd_flags, 4'b0101);
        check("st_mem",   rd_mem,   32'h0040_1234);
        check("st_cycle", rd_cycle, 1);
        check("st_inst",  inst_cnt, 2);
        cycle();
        check("drain_valid", rd_valid, 0);

        // en=0 returns to IDLE with counters held.
        en = 0;
        cycle();
        check("pause_state", state,     0);
        check("pause_cycle", cycle_cnt, 3);
        cycle();
        check("pause_hold",  cycle_cnt, 3);

        // Fill past capacity: 20 pushes into 16 slots.
        restart();
        for (int i = 0; i < 20; i++) begin
            reg_we = 1; reg_addr = 4'(i); reg_data = 16'(i + 100);
            cycle();
        end
        idle();
        check("full_drop",     drop_cnt, 4);
        check("full_overflow", overflow, 1);
        check("full_head",     rd_reg,   20'h00064);
        check("full_inst",     inst_cnt, 20);
        reg_we = 1; reg_data = 16'h0ABC; rd_ready = 1;
        cycle();
        idle();
        rd_ready = 0;
        check("fullpp_drop",  drop_cnt, 4);
        check("fullpp_cycle", rd_cycle, 1);

        // Halt at RUN cycle 7.
        restart();
        rd_ready = 1;
        repeat (7) cycle();
        hlt = 1; rd_ready = 0;
        cycle();
        idle();
        check("hlt_state", state,     2);
        check("hlt_cycle", cycle_cnt, 8);
        check("hlt_flags", rd_flags,  4'b1000);
        check("hlt_rdcyc", rd_cycle,  7);
        check("hlt_inst",  inst_cnt,  1);
        reg_we = 1; reg_data = 16'h5555;
        repeat (3) cycle();
        idle();
        check("hlt_frozen", cycle_cnt, 8);
        check("hlt_noinst", inst_cnt,  1);
        rd_ready = 1;
        cycle();
        check("hlt_drained", rd_valid, 0);

        // Watchdog: TB_MAX RUN cycles without hlt.
        restart();
        repeat (TB_MAX - 2) cycle();
        mem_re = 1; mem_addr = 16'h0100; mem_rdata = 16'hCAFE;
        cycle();
        idle();
        check("pre_to_state", state, 1);
        cycle();
        check("to_state", state,     3);
        check("to_cycle", cycle_cnt, TB_MAX);
        check("to_mem",   rd_mem,    32'h0100_CAFE);
        cycle();
        check("to_frozen", cycle_cnt, TB_MAX);
        rst_n = 0;
        cycle();
        rst_n = 1;
        check("to_rst_state", state,     0);
        check("to_rst_valid", rd_valid,  0);
        check("to_rst_cycle", cycle_cnt, 0);

        // Randomized runs; the compare process checks every cycle against the model.
        for (int run = 0; run < 12; run++) begin
            int ready_pct;
            ready_pct = (run % 3 == 0) ? 10 : 60;
            restart();
            for (int c = 0; c < 150; c++) begin
                rst_n     = ($urandom_range(0, 199) != 0);
                en        = ($urandom_range(0, 19) != 0);
                reg_we    = ($urandom_range(0, 1) == 1);
                mem_re    = ($urandom_range(0, 3) == 0);
                mem_we    = ($urandom_range(0, 3) == 0);
                hlt       = ($urandom_range(0, 59) == 0);
                rd_ready  = ($urandom_range(0, 99) < ready_pct);
                reg_addr  = 4'($urandom);
                reg_data  = 16'($urandom);
                mem_addr  = 16'($urandom);
                mem_wdata = 16'($urandom);
                mem_rdata = 16'($urandom);
                pc        = 16'($urandom);
                inst      = 16'($urandom);
                cycle();
            end
            rst_n = 1;
        end

        idle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
